qracc_window_buffer: RTL and testbench
======================================

# qracc_window_buffer

Double-buffered window assembly stage between the activation buffer read port and the QRAcc MAC array. It collects the per-filter-row activation chunks that the controller streams during compute into a fill bank. On the controller's window-complete pulse it hands the finished window to the MAC through a valid/ready handshake, while the next window fills in the other bank. Its `ready_o` is the `qracc_ready` the controller uses to stall window generation.

## Interface

Parameters:
- `elemWidth` (8): bits per activation element.
- `chunkElems` (16): elements written per write beat; write data is `chunkElems*elemWidth` bits (128 by default).
- `windowElems` (256): elements per window; equals the MAC row count.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  — sole clock; all state changes on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `clear_i`  in  1  — synchronous clear, same effect as reset; takes priority over every other input.
- `wr_en_i`  in  1  — write one chunk into the fill bank.
- `wr_addr_i`  in  32  — element offset of the chunk's element 0 within the window.
- `wr_data_i`  in  `chunkElems*elemWidth`  — chunk data; element k is in bits `[k*elemWidth +: elemWidth]`.
- `commit_i`  in  1  — window complete; hand the fill bank to the MAC.
- `ready_o`  out  1  — a commit is accepted this cycle.
- `win_valid_o`  out  1  — the presented window is valid.
- `win_ready_i`  in  1  — the MAC accepts the presented window.
- `win_data_o`  out  `windowElems*elemWidth`  — the presented window; element i is in bits `[i*elemWidth +: elemWidth]`.
- `win_count_o`  out  32  — number of windows consumed since reset or clear.
- `overflow_err_o`  out  1  — sticky flag: a commit arrived while `ready_o` was low.

## Operation

Storage and bank roles:
- Two banks, A and B, each `windowElems` elements wide.
- `fill_sel_q` selects the fill bank; the other bank is the presented bank.
- `pres_full_q` marks that the presented bank holds a window.

Write:
- When `wr_en_i` is high, element k of the chunk is written to fill-bank element `wr_addr_i + k`.
- The address sum is 33 bits wide, so it does not wrap. Elements whose index is at or above `windowElems` are dropped silently.
- Elements not written since the bank was last zeroed read as 0. This zero value serves as padding.

Commit:
- Accepted when `commit_i && ready_o`.
- Effect of an accepted commit: `fill_sel_q` toggles, `pres_full_q` is set to 1, and the new fill bank (the previously presented bank) is zeroed.
- A write in the same cycle as an accepted commit lands in the bank being committed, before the swap.

Consume:
- Occurs when `win_valid_o && win_ready_i`.
- If a commit is accepted in the same cycle, `pres_full_q` stays at 1 (swap with back-to-back presentation).
- Otherwise `pres_full_q` is cleared to 0.
- Every consume increments `win_count_o`, which wraps modulo 2^32.

Control outputs:
- `ready_o = !pres_full_q || win_ready_i`. This is combinational, with a bypass so that a commit can land in the same cycle as a consume.
- `win_valid_o = pres_full_q`.
- `win_data_o` is the presented bank, muxed directly from registers with no logic beyond the mux.

Commit while `ready_o` is low:
- The commit is ignored.
- The fill bank and its contents are retained.
- `overflow_err_o` is set and stays set until reset or clear.

Reset or clear:
- Both banks are zeroed and `fill_sel_q` = 0 (bank A fills).
- `pres_full_q` = 0, `win_count_o` = 0, `overflow_err_o` = 0.
- `win_valid_o` = 0, `ready_o` = 1, `win_data_o` = 0.
- A reset or clear mid-window discards the partial window.

## Timing

- Write to visibility: a write in cycle t is in the fill bank after the edge ending cycle t.
- Commit to valid: a commit accepted in cycle t gives `win_valid_o` = 1 in cycle t+1, with `win_data_o` including all writes up to and including cycle t.
- Handshake rules:
  - `win_valid_o` stays high and `win_data_o` stays stable until consumed. Writes never alter the presented bank.
  - `win_valid_o` does not depend combinationally on `win_ready_i`.
- Sustained throughput: one window per cycle in the steady state of commit and consume in the same cycle.
- Write while presented: a write while `pres_full_q` is set and no commit occurs targets the fill bank only.

## Test plan

1. **Reset values:** assert `rst`, then release → `ready_o`=1, `win_valid_o`=0, `win_data_o`=0, `win_count_o`=0, `overflow_err_o`=0.
2. **Single window:**
   - Stimulus: write chunk 0x01..0x10 at address 0, chunk 0x11..0x20 at address 16, then commit in cycle t with `win_ready_i`=0.
   - Response: `win_valid_o`=1 at t+1; elements 0..31 = 1..32; elements 32..255 = 0.
   - Then raise `win_ready_i` → `win_valid_o`=0 the next cycle and `win_count_o`=1.
3. **Out-of-range write:** write at address 248 → elements 248..255 are written; chunk elements 8..15 are dropped.
4. **Ping-pong swap:**
   - While window 1 is presented and unconsumed, fill window 2 → window 1 data is unchanged.
   - Commit with `win_ready_i`=1 in the same cycle → `ready_o`=1, `win_valid_o` stays 1, and `win_data_o` becomes window 2 on the next cycle.
   - Elements not written for window 2 read as 0 (no residue from window 1).
5. **Stall and overflow:**
   - Window presented with `win_ready_i`=0 → `ready_o`=0.
   - Commit → commit ignored, `overflow_err_o`=1 and sticky, fill contents kept.
   - A later legal commit delivers those kept contents.
6. **Clear mid-operation:** `clear_i` with one window presented and a partial fill → all outputs return to their reset values next cycle; a fresh window then works as in scenario 2.

Source files
------------

// File: rtl/qracc_window_buffer_if.sv
// Window buffer bus: chunk write port, commit handshake, and presented-window valid/ready port.
// master drives writes/commits and accepts windows; slave is the window buffer.
interface qracc_window_buffer_if #(
   parameter int elemWidth   = 8,
   parameter int chunkElems  = 16,
   parameter int windowElems = 256
);
   logic                                clear_i;
   logic                                wr_en_i;
   logic [31:0]                         wr_addr_i;
   logic [chunkElems*elemWidth-1:0]     wr_data_i;
   logic                                commit_i;
   logic                                ready_o;
   logic                                win_valid_o;
   logic                                win_ready_i;
   logic [windowElems*elemWidth-1:0]    win_data_o;
   logic [31:0]                         win_count_o;
   logic                                overflow_err_o;

   modport master (
      output clear_i, wr_en_i, wr_addr_i, wr_data_i, commit_i, win_ready_i,
      input  ready_o, win_valid_o, win_data_o, win_count_o, overflow_err_o
   );

   modport slave (
      input  clear_i, wr_en_i, wr_addr_i, wr_data_i, commit_i, win_ready_i,
      output ready_o, win_valid_o, win_data_o, win_count_o, overflow_err_o
   );
endinterface

// File: rtl/qracc_window_buffer.sv
// Double-buffered window assembly: chunks fill one bank while the other is presented to the MAC.
// Commit-to-valid is one cycle; ready_o bypasses win_ready_i so commit and consume can share a cycle.
module qracc_window_buffer #(
   parameter int elemWidth   = 8,
   parameter int chunkElems  = 16,
   parameter int windowElems = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   qracc_window_buffer_if.slave    bus
);
   localparam int IW = $clog2(windowElems);

   logic [elemWidth-1:0]             bank_q [2][windowElems];
   logic [elemWidth-1:0]             bank_d [2][windowElems];
   logic                             fill_sel_q, fill_sel_d;
   logic                             pres_full_q, pres_full_d;
   logic [31:0]                      win_count_q, win_count_d;
   logic                             overflow_q, overflow_d;
   logic                             ready;
   logic                             commit_ok;
   logic                             consume;
   logic [windowElems*elemWidth-1:0] win_data;

   assign ready     = !pres_full_q || bus.win_ready_i;
   assign commit_ok = bus.commit_i && ready;
   assign consume   = pres_full_q && bus.win_ready_i;

   assign bus.ready_o        = ready;
   assign bus.win_valid_o    = pres_full_q;
   assign bus.win_count_o    = win_count_q;
   assign bus.overflow_err_o = overflow_q;
   assign bus.win_data_o     = win_data;

   always_comb begin
      win_data = '0;
      for (int i = 0; i < windowElems; i++) begin
         win_data[i*elemWidth +: elemWidth] = bank_q[!fill_sel_q][i];
      end
   end

   always_comb begin
      logic [32:0] idx;
      idx         = '0;
      bank_d      = bank_q;
      fill_sel_d  = fill_sel_q;
      pres_full_d = pres_full_q;
      win_count_d = win_count_q;
      overflow_d  = overflow_q;

      if (bus.clear_i) begin
         bank_d      = '{default: '0};
         fill_sel_d  = 1'b0;
         pres_full_d = 1'b0;
         win_count_d = '0;
         overflow_d  = 1'b0;
      end else begin
         // Writes hit the current fill bank, so a same-cycle commit carries them.
         if (bus.wr_en_i) begin
            for (int k = 0; k < chunkElems; k++) begin
               idx = {1'b0, bus.wr_addr_i} + 33'(k);
               if (idx < 33'(windowElems)) begin
                  bank_d[fill_sel_q][idx[IW-1:0]] = bus.wr_data_i[k*elemWidth +: elemWidth];
               end
            end
         end
         if (commit_ok) begin
            fill_sel_d  = !fill_sel_q;
            pres_full_d = 1'b1;
            for (int i = 0; i < windowElems; i++) begin
               bank_d[!fill_sel_q][i] = '0;
            end
         end else if (consume) begin
            pres_full_d = 1'b0;
         end
         if (consume) begin
            win_count_d = win_count_q + 32'd1;
         end
         if (bus.commit_i && !ready) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q      <= '{default: '0};
         fill_sel_q  <= 1'b0;
         pres_full_q <= 1'b0;
         win_count_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         bank_q      <= bank_d;
         fill_sel_q  <= fill_sel_d;
         pres_full_q <= pres_full_d;
         win_count_q <= win_count_d;
         overflow_q  <= overflow_d;
      end
   end
endmodule

// File: tb/tb_qracc_window_buffer.sv
// Bench for qracc_window_buffer: per-cycle vector table plus a window scoreboard, then an async reset sequence.
module tb_qracc_window_buffer;
   localparam int EW = 8;
   localparam int CE = 16;
   localparam int WE = 256;

   typedef logic [WE*EW-1:0] win_t;

   typedef struct {
      logic        clr;
      logic        we;
      logic [31:0] addr;
      logic [7:0]  base;
      logic        cm;
      logic        wrdy;
      logic        e_rdy;
      logic        e_vld;
      logic [31:0] e_cnt;
      logic        e_ovf;
      logic        e_zero;
   } vec_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_fail;
   win_t model;
   win_t sb[$];
   vec_t tbl[30];

   qracc_window_buffer_if #(.elemWidth(EW), .chunkElems(CE), .windowElems(WE)) bus ();

   qracc_window_buffer #(.elemWidth(EW), .chunkElems(CE), .windowElems(WE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic clr, logic we, logic [31:0] addr, logic [7:0] base,
                               logic cm, logic wrdy, logic e_rdy, logic e_vld,
                               logic [31:0] e_cnt, logic e_ovf, logic e_zero);
      vec_t v;
      v.clr = clr; v.we = we; v.addr = addr; v.base = base; v.cm = cm; v.wrdy = wrdy;
      v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_zero = e_zero;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_win(input string name, input win_t act, input win_t exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         for (int i = 0; i < WE; i++) begin
            if (act[i*EW +: EW] !== exp[i*EW +: EW]) begin
               $display("FAIL %s element %0d actual=%0h expected=%0h",
                        name, i, act[i*EW +: EW], exp[i*EW +: EW]);
               break;
            end
         end
      end
   endtask

   task automatic drive(input vec_t v);
      logic [CE*EW-1:0] d;
      d = '0;
      for (int k = 0; k < CE; k++) d[k*EW +: EW] = 8'(v.base + 8'(k));
      bus.clear_i     = v.clr;
      bus.wr_en_i     = v.we;
      bus.wr_addr_i   = v.addr;
      bus.wr_data_i   = d;
      bus.commit_i    = v.cm;
      bus.win_ready_i = v.wrdy;
   endtask

   // Reference model of the fill bank as a plain element array.
   task automatic model_write(input logic [31:0] addr, input logic [7:0] base);
      logic [32:0] idx;
      for (int k = 0; k < CE; k++) begin
         idx = {1'b0, addr} + 33'(k);
         if (idx < 33'(WE)) model[int'(idx[7:0])*EW +: EW] = 8'(base + 8'(k));
      end
   endtask

   initial begin
      n_vec  = 0;
      n_fail = 0;
      model  = '0;
      rst    = 1'b1;
      drive(mk(0,0,0,0,0,0, 0,0,0,0,0));

      //            clr we addr base cm wr | rdy vld cnt ovf zero
      tbl[0]  = mk(0, 1, 0,   8'h01, 0, 0,   1, 0, 0, 0, 0);
      tbl[1]  = mk(0, 1, 16,  8'h11, 0, 0,   1, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0,   8'h00, 1, 0,   1, 0, 0, 0, 0);
      tbl[3]  = mk(0, 0, 0,   8'h00, 0, 0,   0, 1, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0,   8'h00, 0, 1,   1, 1, 0, 0, 0);
      tbl[5]  = mk(0, 0, 0,   8'h00, 0, 0,   1, 0, 1, 0, 0);
      tbl[6]  = mk(0, 1, 248, 8'hA0, 0, 0,   1, 0, 1, 0, 0);
      tbl[7]  = mk(0, 0, 0,   8'h00, 1, 0,   1, 0, 1, 0, 0);
      tbl[8]  = mk(0, 1, 0,   8'h40, 0, 0,   0, 1, 1, 0, 0);
      tbl[9]  = mk(0, 1, 100, 8'h60, 0, 0,   0, 1, 1, 0, 0);
      tbl[10] = mk(0, 0, 0,   8'h00, 1, 1,   1, 1, 1, 0, 0);
      tbl[11] = mk(0, 0, 0,   8'h00, 0, 0,   0, 1, 2, 0, 0);
      tbl[12] = mk(0, 1, 32,  8'h80, 0, 0,   0, 1, 2, 0, 0);
      tbl[13] = mk(0, 0, 0,   8'h00, 1, 0,   0, 1, 2, 0, 0);
      tbl[14] = mk(0, 0, 0,   8'h00, 0, 0,   0, 1, 2, 1, 0);
      tbl[15] = mk(0, 0, 0,   8'h00, 0, 1,   1, 1, 2, 1, 0);
      tbl[16] = mk(0, 0, 0,   8'h00, 1, 0,   1, 0, 3, 1, 0);
      tbl[17] = mk(0, 0, 0,   8'h00, 0, 1,   1, 1, 3, 1, 0);
      tbl[18] = mk(0, 0, 0,   8'h00, 0, 0,   1, 0, 4, 1, 0);
      tbl[19] = mk(0, 1, 0,   8'h20, 0, 0,   1, 0, 4, 1, 0);
      tbl[20] = mk(0, 0, 0,   8'h00, 1, 0,   1, 0, 4, 1, 0);
      tbl[21] = mk(0, 1, 64,  8'h30, 0, 0,   0, 1, 4, 1, 0);
      tbl[22] = mk(1, 0, 0,   8'h00, 0, 0,   0, 1, 4, 1, 0);
      tbl[23] = mk(0, 0, 0,   8'h00, 0, 0,   1, 0, 0, 0, 1);
      tbl[24] = mk(0, 1, 0,   8'h01, 0, 0,   1, 0, 0, 0, 1);
      tbl[25] = mk(0, 1, 16,  8'h11, 0, 0,   1, 0, 0, 0, 0);
      tbl[26] = mk(0, 0, 0,   8'h00, 1, 0,   1, 0, 0, 0, 0);
      tbl[27] = mk(0, 0, 0,   8'h00, 0, 0,   0, 1, 0, 0, 0);
      tbl[28] = mk(0, 0, 0,   8'h00, 0, 1,   1, 1, 0, 0, 0);
      tbl[29] = mk(0, 0, 0,   8'h00, 0, 0,   1, 0, 1, 0, 0);

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready", 32'(bus.ready_o), 32'd1);
      chk("rst_valid", 32'(bus.win_valid_o), 32'd0);
      chk("rst_count", bus.win_count_o, 32'd0);
      chk("rst_ovf", 32'(bus.overflow_err_o), 32'd0);
      chk_win("rst_data", bus.win_data_o, '0);

      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk($sformatf("v%0d_ready", i), 32'(bus.ready_o), 32'(tbl[i].e_rdy));
         chk($sformatf("v%0d_valid", i), 32'(bus.win_valid_o), 32'(tbl[i].e_vld));
         chk($sformatf("v%0d_count", i), bus.win_count_o, tbl[i].e_cnt);
         chk($sformatf("v%0d_ovf", i), 32'(bus.overflow_err_o), 32'(tbl[i].e_ovf));
         if (tbl[i].e_zero) chk_win($sformatf("v%0d_zero", i), bus.win_data_o, '0);
         if (bus.win_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL v%0d_sb window presented actual=valid required=no pending window", i);
            end else begin
               chk_win($sformatf("v%0d_data", i), bus.win_data_o, sb[0]);
            end
         end
         if (tbl[i].clr) begin
            sb.delete();
            model = '0;
         end else begin
            if (tbl[i].e_vld && tbl[i].wrdy && sb.size() > 0) void'(sb.pop_front());
            if (tbl[i].we) model_write(tbl[i].addr, tbl[i].base);
            if (tbl[i].cm && tbl[i].e_rdy) begin
               sb.push_back(model);
               model = '0;
            end
         end
      end
      chk("sb_drain", 32'(sb.size()), 32'd0);

      // Async reset while a window is presented: outputs drop without a clock edge.
      @(negedge clk);
      drive(mk(0, 1, 0, 8'h05, 1, 0, 0,0,0,0,0));
      @(negedge clk);
      drive(mk(0, 0, 0, 8'h00, 0, 0, 0,0,0,0,0));
      #1;
      chk("hs_valid", 32'(bus.win_valid_o), 32'd1);
      chk("hs_elem0", 32'(bus.win_data_o[7:0]), 32'h05);
      #2;
      rst = 1'b1;
      #1;
      chk("hs_rst_valid", 32'(bus.win_valid_o), 32'd0);
      chk("hs_rst_ready", 32'(bus.ready_o), 32'd1);
      chk("hs_rst_count", bus.win_count_o, 32'd0);
      chk_win("hs_rst_data", bus.win_data_o, '0);
      @(negedge clk);
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
